// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port synchronous RAM.
// One access per IDLE -> ACCESS -> WAIT pass; round-robin on contention.
module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic              if_err,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic              d_err,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t              state_q;
    owner_t              owner_q;
    owner_t              last_q;
    logic                err_q;
    logic                we_q;

    logic                pick_d;
    logic [1:0]          sel_lo;
    logic [ADDR_W-1:0]   sel_idx;
    logic                sel_mis;

    // Address bits above the RAM window are ignored, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

    // NOTE: every always_comb output gets a value on every path, so no latch can form.
    always_comb begin
        pick_d  = d_req && (!if_req || (last_q == OWN_IF));
        sel_lo  = pick_d ? d_addr[1:0] : if_addr[1:0];
        sel_idx = pick_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        sel_mis = (sel_lo != 2'b00);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values of the others regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            last_q    <= OWN_D;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_err   <= 1'b0;
            d_err    <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_q   <= pick_d ? OWN_D : OWN_IF;
                        last_q    <= pick_d ? OWN_D : OWN_IF;
                        err_q     <= sel_mis;
                        we_q      <= pick_d && d_we;
                        if_gnt    <= !pick_d;
                        d_gnt     <= pick_d;
                        // Misaligned accesses never touch the RAM.
                        mem_en    <= !sel_mis;
                        mem_we    <= !sel_mis && pick_d && d_we;
                        mem_addr  <= sel_idx;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        state_q   <= ACCESS;
                    end
                end

                ACCESS: state_q <= WAIT;

                WAIT: begin
                    state_q <= IDLE;
                    if (owner_q == OWN_IF) begin
                        if_valid <= 1'b1;
                        if_err   <= err_q;
                        if (!err_q) if_rdata <= mem_rdata;
                    end else begin
                        d_valid <= 1'b1;
                        d_err   <= err_q;
                        if (!err_q && !we_q) d_rdata <= mem_rdata;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle-scheduled transaction model plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_valid, if_err;
    logic        d_gnt, d_valid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment RAM: single port, data one cycle after mem_en.
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct packed {
        bit          if_gnt, d_gnt, en, we, if_valid, d_valid, if_err, d_err, upd_if, upd_d;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sched [int];
    logic [31:0] mdl_mem [1024];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    int          cyc     = 0;
    int          free_at = 0;
    bit          last_d  = 1'b1;

    task automatic model_step();
        exp_t        e;
        exp_t        v;
        bit          win_d, mis, we;
        logic [31:0] a;
        logic [9:0]  idx;
        int          keys[$];
        cyc++;
        if (!rst_n) begin
            foreach (sched[k]) if (k >= cyc) keys.push_back(k);
            foreach (keys[i]) sched.delete(keys[i]);
            last_d       = 1'b1;
            free_at      = cyc + 1;
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            return;
        end
        if (sched.exists(cyc)) begin
            if (sched[cyc].upd_if) exp_if_rdata = sched[cyc].rdata;
            if (sched[cyc].upd_d)  exp_d_rdata  = sched[cyc].rdata;
        end
        if (cyc >= free_at && (if_req || d_req)) begin
            win_d  = d_req && (!if_req || !last_d);
            last_d = win_d;
            a      = win_d ? d_addr : if_addr;
            mis    = (a[1:0] != 2'b00);
            we     = win_d && d_we;
            idx    = a[11:2];
            e = '0;
            e.if_gnt = !win_d;
            e.d_gnt  = win_d;
            e.en     = !mis;
            e.we     = !mis && we;
            e.addr   = idx;
            e.wdata  = d_wdata;
            sched[cyc] = e;
            v = '0;
            v.rdata = mdl_mem[idx];
            if (win_d) begin
                v.d_valid = 1'b1;
                v.d_err   = mis;
                v.upd_d   = !mis && !we;
            end else begin
                v.if_valid = 1'b1;
                v.if_err   = mis;
                v.upd_if   = !mis;
            end
            if (!mis && we) mdl_mem[idx] = d_wdata;
            sched[cyc + 2] = v;
            free_at = cyc + 3;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (cyc > 0) begin
            e = sched.exists(cyc) ? sched[cyc] : exp_t'('0);
            check("ctl{ig,dg,iv,dv,ie,de,en,we}",
                  {56'd0, if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, mem_en, mem_we},
                  {56'd0, e.if_gnt, e.d_gnt, e.if_valid, e.d_valid, e.if_err, e.d_err, e.en, e.we});
            if (e.en) check("mem_addr", {54'd0, mem_addr}, {54'd0, e.addr});
            if (e.we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
            check("if_rdata", {32'd0, if_rdata}, {32'd0, exp_if_rdata});
            check("d_rdata", {32'd0, d_rdata}, {32'd0, exp_d_rdata});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, output int g_rel, output int v_rel,
                             output int en_cnt, output logic err, output logic [31:0] rdata);
        int t0;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        t0 = cyc; g_rel = -1; v_rel = -1; en_cnt = 0; err = 1'bx; rdata = 'x;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (g_rel < 0 && (is_d ? d_gnt : if_gnt)) begin
                g_rel = cyc - t0;
                if (is_d) d_req = 1'b0; else if_req = 1'b0;
            end
            if (is_d ? d_valid : if_valid) begin
                v_rel = cyc - t0;
                err   = is_d ? d_err : if_err;
                rdata = is_d ? d_rdata : if_rdata;
                break;
            end
        end
        if (v_rel < 0) begin
            check("access_timeout", 64'd0, 64'd1);
            d_req = 1'b0; if_req = 1'b0;
        end
    endtask

    int          g_rel, v_rel, en_cnt, dbl, vcnt;
    logic        err;
    logic [31:0] rdata, ram0_snap;
    bit          glog[$];
    bit          exp_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]     <= 32'h1000_0000 + i;
            mdl_mem[i]  = 32'h1000_0000 + i;
        end
        ram[1]     <= 32'hFFC2_8293;
        mdl_mem[1]  = 32'hFFC2_8293;

        // Reset held with both requests high: nothing may be granted.
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_hold_outputs", {56'd0, if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, if_err, d_err}, 64'd0);
        check("reset_hold_rdata", {if_rdata, d_rdata}, 64'd0);
        if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Fetch only from 0x4.
        do_access(1'b0, 1'b0, 32'h4, 32'h0, g_rel, v_rel, en_cnt, err, rdata);
        check("fetch_gnt_cycle", g_rel, 64'd1);
        check("fetch_valid_cycle", v_rel, 64'd3);
        check("fetch_rdata", rdata, 64'hFFC2_8293);
        check("fetch_err", {63'd0, err}, 64'd0);

        // Store then load at the top word (address wraps to word 1023).
        do_access(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd1337, g_rel, v_rel, en_cnt, err, rdata);
        check("sw_valid_cycle", v_rel, 64'd3);
        check("sw_ram1023", ram[1023], 64'd1337);
        do_access(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, g_rel, v_rel, en_cnt, err, rdata);
        check("lw_rdata", rdata, 64'h0000_0539);
        check("lw_err", {63'd0, err}, 64'd0);

        // Misaligned store: no RAM activity, error response.
        ram0_snap = ram[0];
        do_access(1'b1, 1'b1, 32'h2, 32'hDEAD_BEEF, g_rel, v_rel, en_cnt, err, rdata);
        check("mis_mem_en_cycles", en_cnt, 64'd0);
        check("mis_err", {63'd0, err}, 64'd1);
        check("mis_valid_cycle", v_rel, 64'd3);
        check("mis_ram0", ram[0], {32'd0, ram0_snap});

        // Sustained contention: alternating grants starting with fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        glog.delete(); dbl = 0;
        for (int n = 0; n < 40 && glog.size() < 4; n++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) dbl++;
            if (if_gnt) glog.push_back(1'b0);
            if (d_gnt)  glog.push_back(1'b1);
        end
        if_req = 1'b0; d_req = 1'b0;
        check("rr_grant_count", glog.size(), 64'd4);
        check("rr_double_grant", dbl, 64'd0);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check($sformatf("rr_order%0d", i), {63'd0, glog[i]}, {63'd0, exp_order[i]});
        repeat (4) @(negedge clk);

        // Reset during WAIT of a fetch aborts the response.
        if_req = 1'b1; if_addr = 32'h4;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (if_gnt) break;
        end
        check("abort_fetch_gnt", {63'd0, if_gnt}, 64'd1);
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outputs_zero", {56'd0, if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, if_err, d_err}, 64'd0);
        check("abort_rdata_zero", {if_rdata, d_rdata}, 64'd0);
        check("abort_mem_bus_zero", {22'd0, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_valid) vcnt++;
        end
        check("abort_no_valid", vcnt, 64'd0);

        if_req = 1'b1; if_addr = 32'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) break;
        end
        check("post_reset_first_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        if_req = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d_gnt) break;
        end
        check("post_reset_second_gnt", {63'd0, d_gnt}, 64'd1);
        d_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
